// File: rtl/syn_cortex_lb_arb_if.sv
// Cortex local-bus link: request side drives strobes/address/data,
// completion side returns valids and read data.
interface syn_cortex_lb_arb_if #(
  parameter int P_DATA_W = 32,
  parameter int P_ADDR_W = 16
) ();
  logic                rd_en;
  logic                wr_en;
  logic [P_ADDR_W-1:0] addr;
  logic [P_DATA_W-1:0] wr_data;
  logic                rd_valid;
  logic                wr_valid;
  logic [P_DATA_W-1:0] rd_data;

  modport master (
    output rd_en, wr_en, addr, wr_data,
    input  rd_valid, wr_valid, rd_data
  );

  modport slave (
    input  rd_en, wr_en, addr, wr_data,
    output rd_valid, wr_valid, rd_data
  );
endinterface

// File: rtl/syn_cortex_lb_arb.sv
// Two-master round-robin arbiter for the cortex local bus,
// one transaction in flight, with a bus-hang timeout.
module syn_cortex_lb_arb #(
  parameter int                  P_DATA_W   = 32,
  parameter int                  P_ADDR_W   = 16,
  parameter int                  P_TIMEOUT  = 64,
  parameter logic [P_DATA_W-1:0] P_TO_RDATA = 32'hDEADDEAD
) (
  input  logic                   clk_ir,
  input  logic                   rst_ih,
  syn_cortex_lb_arb_if.slave     m0,
  syn_cortex_lb_arb_if.slave     m1,
  syn_cortex_lb_arb_if.master    s,
  output logic                   gnt_id_o,
  output logic                   to_err_oh
);

  localparam int LP_CW = (P_TIMEOUT > 2) ? $clog2(P_TIMEOUT) : 1;
  localparam logic [LP_CW-1:0] LP_TO_LAST = LP_CW'(P_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  logic                r_last;
  logic                r_gnt;
  logic                r_op_wr;
  logic [LP_CW-1:0]    r_cnt;
  logic                r_s_rd_en;
  logic                r_s_wr_en;
  logic [P_ADDR_W-1:0] r_s_addr;
  logic [P_DATA_W-1:0] r_s_wdata;
  logic                r_m0_rd_valid;
  logic                r_m0_wr_valid;
  logic [P_DATA_W-1:0] r_m0_rd_data;
  logic                r_m1_rd_valid;
  logic                r_m1_wr_valid;
  logic [P_DATA_W-1:0] r_m1_rd_data;
  logic                r_to_err;

  logic                w_req0;
  logic                w_req1;
  logic                w_pick;
  logic                w_wr;
  logic [P_ADDR_W-1:0] w_addr;
  logic [P_DATA_W-1:0] w_wdata;
  logic                w_done;
  logic                w_to;
  logic [P_DATA_W-1:0] w_rdat;

  assign w_req0 = m0.rd_en | m0.wr_en;
  assign w_req1 = m1.rd_en | m1.wr_en;

  // Contention goes to whichever master was not granted last.
  always_comb begin
    w_pick = 1'b0;
    unique case (1'b1)
      (w_req0 & w_req1):  w_pick = ~r_last;
      (w_req1 & ~w_req0): w_pick = 1'b1;
      default:            w_pick = 1'b0;
    endcase
  end

  // A master holding both strobes is served its write first.
  assign w_wr    = w_pick ? m1.wr_en   : m0.wr_en;
  assign w_addr  = w_pick ? m1.addr    : m0.addr;
  assign w_wdata = w_pick ? m1.wr_data : m0.wr_data;

  assign w_done = r_op_wr ? s.wr_valid : s.rd_valid;
  assign w_to   = (r_cnt == LP_TO_LAST);
  assign w_rdat = r_op_wr ? '0 :
                  (w_done ? s.rd_data : P_TO_RDATA);

  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      r_state       <= S_IDLE;
      r_last        <= 1'b1;
      r_gnt         <= 1'b0;
      r_op_wr       <= 1'b0;
      r_cnt         <= '0;
      r_s_rd_en     <= 1'b0;
      r_s_wr_en     <= 1'b0;
      r_s_addr      <= '0;
      r_s_wdata     <= '0;
      r_m0_rd_valid <= 1'b0;
      r_m0_wr_valid <= 1'b0;
      r_m0_rd_data  <= '0;
      r_m1_rd_valid <= 1'b0;
      r_m1_wr_valid <= 1'b0;
      r_m1_rd_data  <= '0;
      r_to_err      <= 1'b0;
    end else begin
      r_s_rd_en     <= 1'b0;
      r_s_wr_en     <= 1'b0;
      r_m0_rd_valid <= 1'b0;
      r_m0_wr_valid <= 1'b0;
      r_m1_rd_valid <= 1'b0;
      r_m1_wr_valid <= 1'b0;
      r_to_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req0 | w_req1) begin
            r_gnt     <= w_pick;
            r_last    <= w_pick;
            r_op_wr   <= w_wr;
            r_s_addr  <= w_addr;
            r_s_wdata <= w_wdata;
            r_s_wr_en <= w_wr;
            r_s_rd_en <= ~w_wr;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A valid in the final timeout cycle still wins.
          if (w_done | w_to) begin
            if (r_gnt) begin
              r_m1_rd_valid <= ~r_op_wr;
              r_m1_wr_valid <= r_op_wr;
              r_m1_rd_data  <= w_rdat;
            end else begin
              r_m0_rd_valid <= ~r_op_wr;
              r_m0_wr_valid <= r_op_wr;
              r_m0_rd_data  <= w_rdat;
            end
            r_to_err <= ~w_done;
            r_state  <= S_RESP;
          end
        end
        S_RESP: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s.rd_en     = r_s_rd_en;
  assign s.wr_en     = r_s_wr_en;
  assign s.addr      = r_s_addr;
  assign s.wr_data   = r_s_wdata;
  assign m0.rd_valid = r_m0_rd_valid;
  assign m0.wr_valid = r_m0_wr_valid;
  assign m0.rd_data  = r_m0_rd_data;
  assign m1.rd_valid = r_m1_rd_valid;
  assign m1.wr_valid = r_m1_wr_valid;
  assign m1.rd_data  = r_m1_rd_data;
  assign gnt_id_o    = r_gnt;
  assign to_err_oh   = r_to_err;

endmodule

// File: tb/tb_syn_cortex_lb_arb.sv
// Scoreboard bench for the cortex LB arbiter: expected issues and
// responses are queued at stimulus time and checked at the outputs.
module tb_syn_cortex_lb_arb;

  logic clk = 1'b0;
  logic rst_ih = 1'b1;
  int   cyc = 0;
  int   n_tot = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  syn_cortex_lb_arb_if #(.P_DATA_W(32), .P_ADDR_W(16)) im0 ();
  syn_cortex_lb_arb_if #(.P_DATA_W(32), .P_ADDR_W(16)) im1 ();
  syn_cortex_lb_arb_if #(.P_DATA_W(32), .P_ADDR_W(16)) is ();

  logic gnt_id_o;
  logic to_err_oh;

  syn_cortex_lb_arb #(
    .P_DATA_W(32), .P_ADDR_W(16), .P_TIMEOUT(64),
    .P_TO_RDATA(32'hDEADDEAD)
  ) dut (
    .clk_ir(clk), .rst_ih(rst_ih),
    .m0(im0), .m1(im1), .s(is),
    .gnt_id_o(gnt_id_o), .to_err_oh(to_err_oh)
  );

  typedef struct {
    bit          m;
    bit          wr;
    logic [15:0] a;
    logic [31:0] d;
    int          gap;
  } iss_t;

  typedef struct {
    bit          m;
    bit          wr;
    logic [31:0] d;
    bit          err;
    int          lat;
  } rsp_t;

  iss_t q_iss[$];
  rsp_t q_rsp[$];
  int   t_iss = 0;

  int          sl_dly = 1;
  bit          sl_silent = 1'b0;
  bit          sl_wrong = 1'b0;
  logic [31:0] sl_data = '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic set_m(input bit m, input bit rd, input bit wr,
                       input logic [15:0] a, input logic [31:0] d);
    if (m) begin
      im1.rd_en = rd; im1.wr_en = wr;
      im1.addr = a;   im1.wr_data = d;
    end else begin
      im0.rd_en = rd; im0.wr_en = wr;
      im0.addr = a;   im0.wr_data = d;
    end
  endtask

  // Raise a request, drop each strobe on the edge ending its RESP.
  task automatic m_run(input bit m, input bit rd, input bit wr,
                       input logic [15:0] a, input logic [31:0] d);
    bit prd = rd;
    bit pwr = wr;
    bit seen;
    int n = 0;
    set_m(m, prd, pwr, a, d);
    while ((prd | pwr) && n < 300) begin
      @(negedge clk);
      n++;
      seen = 1'b0;
      if (m ? im1.wr_valid : im0.wr_valid) begin pwr = 0; seen = 1; end
      if (m ? im1.rd_valid : im0.rd_valid) begin prd = 0; seen = 1; end
      if (seen) begin
        @(posedge clk); #1;
        set_m(m, prd, pwr, a, d);
      end
    end
    chk($sformatf("m%0d_done", m), n < 300, 1'b1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_m0"}, {im0.rd_valid, im0.wr_valid, im0.rd_data}, '0);
    chk({tag, "_m1"}, {im1.rd_valid, im1.wr_valid, im1.rd_data}, '0);
    chk({tag, "_sen"}, {is.rd_en, is.wr_en}, '0);
    chk({tag, "_sbus"}, {is.addr, is.wr_data}, '0);
    chk({tag, "_misc"}, {gnt_id_o, to_err_oh}, '0);
  endtask

  task automatic push(input bit m, input bit wr, input logic [15:0] a,
                      input logic [31:0] wd, input int gap,
                      input logic [31:0] rd, input bit err, input int lat);
    q_iss.push_back('{m: m, wr: wr, a: a, d: wd, gap: gap});
    q_rsp.push_back('{m: m, wr: wr, d: rd, err: err, lat: lat});
  endtask

  // Slave model: answers each strobe sl_dly cycles later.
  initial begin
    bit w;
    is.rd_valid = 0; is.wr_valid = 0; is.rd_data = '0;
    forever begin
      @(negedge clk);
      if ((is.rd_en | is.wr_en) && !sl_silent) begin
        w = is.wr_en;
        for (int i = 1; i <= sl_dly; i++) begin
          @(negedge clk);
          is.rd_valid = 0; is.wr_valid = 0;
          if (sl_wrong && i == 1) begin
            if (w) is.rd_valid = 1; else is.wr_valid = 1;
          end
        end
        if (w) is.wr_valid = 1;
        else begin is.rd_valid = 1; is.rd_data = sl_data; end
        @(negedge clk);
        is.rd_valid = 0; is.wr_valid = 0;
      end
    end
  end

  // Output monitor against the scoreboard queues.
  initial begin
    iss_t ei;
    rsp_t er;
    bit   v0, v1;
    forever begin
      @(negedge clk);
      if (!rst_ih && (is.rd_en | is.wr_en)) begin
        chk("iss_q", q_iss.size() != 0, 1'b1);
        if (q_iss.size() != 0) begin
          ei = q_iss.pop_front();
          chk("iss_gnt", gnt_id_o, ei.m);
          chk("iss_op", {is.wr_en, is.rd_en}, {ei.wr, ~ei.wr});
          chk("iss_addr", is.addr, ei.a);
          if (ei.wr) chk("iss_wdata", is.wr_data, ei.d);
          if (ei.gap != 0) chk("iss_gap", cyc - t_iss, ei.gap);
        end
        t_iss = cyc;
      end
      v0 = im0.rd_valid | im0.wr_valid;
      v1 = im1.rd_valid | im1.wr_valid;
      if (v0 | v1) begin
        chk("rsp_q", q_rsp.size() != 0, 1'b1);
        if (q_rsp.size() != 0) begin
          er = q_rsp.pop_front();
          chk("rsp_m", {v1, v0}, {er.m, ~er.m});
          chk("rsp_op", v1 ? im1.wr_valid : im0.wr_valid, er.wr);
          chk("rsp_data", v1 ? im1.rd_data : im0.rd_data, er.d);
          chk("rsp_err", to_err_oh, er.err);
          chk("rsp_lat", cyc - t_iss, er.lat);
        end
      end else if (to_err_oh) begin
        chk("err_stray", to_err_oh, 1'b0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    set_m(0, 0, 0, '0, '0);
    set_m(1, 0, 0, '0, '0);
    repeat (2) @(negedge clk);
    chk_zero("rst0");
    @(posedge clk); #1 rst_ih = 0;
    repeat (2) @(posedge clk); #1;

    // 1: single m0 read, slave answers 3 cycles after the strobe
    sl_dly = 3; sl_data = 32'hA5A50001;
    push(0, 0, 16'h1004, '0, 0, 32'hA5A50001, 0, 4);
    m_run(0, 1, 0, 16'h1004, '0);
    chk("t1_m1_rdata", im1.rd_data, 32'h0);

    // 2: both masters writing; m0 re-requests, giving m0,m1,m0
    rst_ih = 1;
    repeat (2) @(posedge clk); #1 rst_ih = 0;
    @(posedge clk); #1;
    sl_dly = 1;
    push(0, 1, 16'h1100, 32'h11111111, 0, '0, 0, 2);
    push(1, 1, 16'h2200, 32'h22222222, 4, '0, 0, 2);
    push(0, 1, 16'h1100, 32'h11111111, 4, '0, 0, 2);
    fork
      begin
        m_run(0, 0, 1, 16'h1100, 32'h11111111);
        m_run(0, 0, 1, 16'h1100, 32'h11111111);
      end
      m_run(1, 0, 1, 16'h2200, 32'h22222222);
    join
    repeat (3) @(posedge clk); #1;

    // 4: rd+wr held together, write goes first
    sl_dly = 2; sl_data = 32'h0BADF00D;
    push(0, 1, 16'h1000, 32'h55, 0, '0, 0, 3);
    push(0, 0, 16'h1000, '0, 0, 32'h0BADF00D, 0, 3);
    m_run(0, 1, 1, 16'h1000, 32'h55);
    repeat (3) @(posedge clk); #1;

    // 6: wrong-type valid during read WAIT is ignored
    sl_dly = 4; sl_wrong = 1; sl_data = 32'h600DCAFE;
    push(1, 0, 16'h2ABC, '0, 0, 32'h600DCAFE, 0, 5);
    m_run(1, 1, 0, 16'h2ABC, '0);
    sl_wrong = 0;
    repeat (3) @(posedge clk); #1;

    // 3: silent slave, timeout, then a late read valid
    sl_silent = 1;
    push(1, 0, 16'h2010, '0, 0, 32'hDEADDEAD, 1, 65);
    m_run(1, 1, 0, 16'h2010, '0);
    repeat (3) @(negedge clk);
    is.rd_valid = 1; is.rd_data = 32'h12345678;
    @(negedge clk);
    is.rd_valid = 0;
    repeat (4) @(negedge clk);
    chk("t3_m1_hold", im1.rd_data, 32'hDEADDEAD);
    sl_silent = 0;
    @(posedge clk); #1;

    // 5: reset two cycles into WAIT; late slave valid must vanish
    sl_dly = 6; sl_data = 32'h77777777;
    q_iss.push_back('{m: 0, wr: 0, a: 16'h1008, d: '0, gap: 0});
    set_m(0, 1, 0, 16'h1008, '0);
    n = 0;
    do begin @(negedge clk); n++; end while (!is.rd_en && n < 20);
    chk("t5_strobe", is.rd_en, 1'b1);
    repeat (2) @(negedge clk);
    rst_ih = 1;
    set_m(0, 0, 0, '0, '0);
    @(negedge clk);
    chk_zero("rst5");
    @(posedge clk); #1 rst_ih = 0;
    repeat (8) @(negedge clk);
    chk("t5_m0_quiet", im0.rd_data, 32'h0);
    @(posedge clk); #1;
    sl_dly = 2; sl_data = 32'hC0FFEE00;
    push(0, 0, 16'h1010, '0, 0, 32'hC0FFEE00, 0, 3);
    m_run(0, 1, 0, 16'h1010, '0);

    repeat (4) @(negedge clk);
    chk("iss_left", q_iss.size(), 0);
    chk("rsp_left", q_rsp.size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
